// File: rtl/time_conv_arbiter.sv
// Round-robin arbiter sharing one multicycle seconds-to-calendar converter
// between the live-clock port (0) and the event-timestamp port (1).

module binary_time_converter (
  input  logic [27:0] t,
  output logic [4:0]  hh,
  output logic [5:0]  mm,
  output logic [5:0]  ss,
  output logic [4:0]  dd,
  output logic [3:0]  mo,
  output logic [10:0] yyyy,
  output logic        oor
);
  // Day numbers of Jan 1st for 2020..2026; the last entry is the range limit.
  localparam logic [11:0] YSTART [7] = '{12'd0, 12'd366, 12'd731, 12'd1096,
                                         12'd1461, 12'd1827, 12'd2192};
  localparam logic [8:0]  MSTART [12] = '{9'd0, 9'd31, 9'd59, 9'd90, 9'd120, 9'd151,
                                          9'd181, 9'd212, 9'd243, 9'd273, 9'd304, 9'd334};

  logic [11:0] days;
  logic [16:0] sod;
  logic [5:0]  year_ge;
  logic [2:0]  yidx;
  logic [8:0]  doy;
  logic        leap;
  logic [8:0]  mbase [12];
  logic [10:0] mon_ge;
  logic [3:0]  midx;

  always_comb begin
    days = 12'(t / 28'd86400);
    sod  = 17'(t % 28'd86400);
    hh   = 5'(sod / 17'd3600);
    mm   = 6'((sod % 17'd3600) / 17'd60);
    ss   = 6'(sod % 17'd60);
  end

  genvar gi;
  for (gi = 0; gi < 6; gi++) begin : g_year
    assign year_ge[gi] = (days >= YSTART[gi+1]);
  end

  // year_ge is thermometer coded, so the highest set bit gives the year index.
  always_comb begin
    yidx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (year_ge[i]) yidx = 3'(i + 1);
    end
    doy  = 9'(days - YSTART[yidx]);
    leap = (yidx == 3'd0) || (yidx == 3'd4);
    oor  = year_ge[5];
  end

  always_comb begin
    for (int i = 0; i < 12; i++) begin
      mbase[i] = MSTART[i] + ((leap && i >= 2) ? 9'd1 : 9'd0);
    end
  end

  for (gi = 0; gi < 11; gi++) begin : g_month
    assign mon_ge[gi] = (doy >= mbase[gi+1]);
  end

  always_comb begin
    midx = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (mon_ge[i]) midx = 4'(i + 1);
    end
    if (oor) begin
      dd   = 5'd0;
      mo   = 4'd0;
      yyyy = 11'd0;
    end else begin
      dd   = 5'(doy - mbase[midx] + 9'd1);
      mo   = midx + 4'd1;
      yyyy = 11'd2020 + 11'(yidx);
    end
  end
endmodule

module time_conv_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [27:0] t0,
  input  logic        req1,
  input  logic [27:0] t1,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        done0,
  output logic        done1,
  output logic [4:0]  hh,
  output logic [5:0]  mm,
  output logic [5:0]  ss,
  output logic [4:0]  DD,
  output logic [3:0]  MM,
  output logic [10:0] YYYY,
  output logic        range_err
);
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [27:0] t_reg;
  logic        last_reg;

  logic [4:0]  c_hh;
  logic [5:0]  c_mm;
  logic [5:0]  c_ss;
  logic [4:0]  c_dd;
  logic [3:0]  c_mo;
  logic [10:0] c_yyyy;
  logic        c_oor;

  logic elig0, elig1, pick1;

  binary_time_converter u_conv (
    .t    (t_reg),
    .hh   (c_hh),
    .mm   (c_mm),
    .ss   (c_ss),
    .dd   (c_dd),
    .mo   (c_mo),
    .yyyy (c_yyyy),
    .oor  (c_oor)
  );

  // A port whose done is showing is not eligible; its next request starts a cycle later.
  always_comb begin
    elig0 = req0 && !done0;
    elig1 = req1 && !done1;
    pick1 = elig1 && (!elig0 || !last_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      t_reg     <= 28'd0;
      last_reg  <= 1'b1;
      gnt       <= 2'b00;
      busy      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      hh        <= 5'd0;
      mm        <= 6'd0;
      ss        <= 6'd0;
      DD        <= 5'd0;
      MM        <= 4'd0;
      YYYY      <= 11'd0;
      range_err <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (elig0 || elig1) begin
            t_reg     <= pick1 ? t1 : t0;
            gnt       <= pick1 ? 2'b10 : 2'b01;
            busy      <= 1'b1;
            cnt_reg   <= CNT_INIT;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            hh        <= c_hh;
            mm        <= c_mm;
            ss        <= c_ss;
            DD        <= c_dd;
            MM        <= c_mo;
            YYYY      <= c_yyyy;
            range_err <= c_oor;
            done0     <= gnt[0];
            done1     <= gnt[1];
            last_reg  <= gnt[1];
            gnt       <= 2'b00;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_time_conv_arbiter.sv
// Scoreboard bench for time_conv_arbiter: directed requests with hand-computed
// calendar results, plus LAT=1 and LAT=15 instances for latency extremes.

module tb_time_conv_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Main LAT=2 instance
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [27:0] t0 = '0, t1 = '0;
  logic [1:0]  gnt;
  logic        busy, done0, done1, range_err;
  logic [4:0]  hh, dd;
  logic [5:0]  mm, ss;
  logic [3:0]  mo;
  logic [10:0] yy;

  time_conv_arbiter #(.LAT(2)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .t0(t0), .req1(req1), .t1(t1),
    .gnt(gnt), .busy(busy), .done0(done0), .done1(done1),
    .hh(hh), .mm(mm), .ss(ss), .DD(dd), .MM(mo), .YYYY(yy), .range_err(range_err)
  );

  // LAT=1 and LAT=15 instances share one port-1 stimulus
  logic        r_req = 1'b0;
  logic [27:0] r_t = '0;
  logic        lo_req0 = 1'b0;
  logic [27:0] lo_t0 = '0;
  logic [1:0]  a_gnt, b_gnt;
  logic        a_busy, a_done0, a_done1, a_re, b_busy, b_done0, b_done1, b_re;
  logic [4:0]  a_hh, a_dd, b_hh, b_dd;
  logic [5:0]  a_mm, a_ss, b_mm, b_ss;
  logic [3:0]  a_mo, b_mo;
  logic [10:0] a_yy, b_yy;

  time_conv_arbiter #(.LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req0(lo_req0), .t0(lo_t0), .req1(r_req), .t1(r_t),
    .gnt(a_gnt), .busy(a_busy), .done0(a_done0), .done1(a_done1),
    .hh(a_hh), .mm(a_mm), .ss(a_ss), .DD(a_dd), .MM(a_mo), .YYYY(a_yy), .range_err(a_re)
  );

  time_conv_arbiter #(.LAT(15)) u_lat15 (
    .clk(clk), .rst(rst), .req0(lo_req0), .t0(lo_t0), .req1(r_req), .t1(r_t),
    .gnt(b_gnt), .busy(b_busy), .done0(b_done0), .done1(b_done1),
    .hh(b_hh), .mm(b_mm), .ss(b_ss), .DD(b_dd), .MM(b_mo), .YYYY(b_yy), .range_err(b_re)
  );

  typedef struct {
    int port;
    int hh, mm, ss, dd, mo, yy, re;
    bit chk_date;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void push(input int port, input int h, input int m, input int s,
                               input int d, input int mon, input int y, input int re,
                               input bit cd);
    exp_t e;
    e.port = port; e.hh = h; e.mm = m; e.ss = s;
    e.dd = d; e.mo = mon; e.yy = y; e.re = re; e.chk_date = cd;
    sbq.push_back(e);
  endfunction

  // Monitor: every done pulse on the main instance pops one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (done0 && done1) begin
        total++; bad++;
        $display("FAIL done_onehot: got done0=1 done1=1 expected at most one");
      end else if (done0 || done1) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done0=%0d done1=%0d expected none", done0, done1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_port", done1 ? 1 : 0, e.port);
          chk("sb_hh", hh, e.hh);
          chk("sb_mm", mm, e.mm);
          chk("sb_ss", ss, e.ss);
          if (e.chk_date) begin
            chk("sb_DD", dd, e.dd);
            chk("sb_MM", mo, e.mo);
          end
          chk("sb_YYYY", yy, e.yy);
          chk("sb_range_err", range_err, e.re);
          $display("done port=%0d %0d:%0d:%0d %0d-%0d-%0d re=%0d", done1 ? 1 : 0,
                   hh, mm, ss, yy, mo, dd, range_err);
        end
      end
    end
  end

  task automatic wait_done(input int port, input int budget, output int c);
    bit found = 1'b0;
    c = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if ((port == 0) ? done0 : done1) begin
        found = 1'b1;
        c = cyc;
      end
    end
    if (!found) chk($sformatf("timeout_done%0d", port), 0, 1);
  endtask

  task automatic check_outputs_zero(input string pfx);
    chk({pfx, "_gnt"}, gnt, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, {done1, done0}, 0);
    chk({pfx, "_hh"}, hh, 0);
    chk({pfx, "_mm"}, mm, 0);
    chk({pfx, "_ss"}, ss, 0);
    chk({pfx, "_DD"}, dd, 0);
    chk({pfx, "_MM"}, mo, 0);
    chk({pfx, "_YYYY"}, yy, 0);
    chk({pfx, "_range_err"}, range_err, 0);
  endtask

  initial begin
    int ts, c0, c1, c2, ca, cb, ndone;
    logic [31:0] ares [6];
    logic [31:0] bres [6];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Basic latency; t0 change after grant must be ignored
    @(negedge clk);
    req0 = 1'b1; t0 = 28'd3661; ts = cyc;
    push(0, 1, 1, 1, 1, 1, 2020, 0, 1);
    @(negedge clk);
    chk("basic_gnt", gnt, 1);
    chk("basic_busy", busy, 1);
    t0 = 28'd99999;
    wait_done(0, 20, c0);
    req0 = 1'b0;
    chk("basic_latency", c0 - ts, 3);
    chk("basic_gnt_done", gnt, 0);
    chk("basic_busy_done", busy, 0);
    repeat (2) @(negedge clk);
    chk("hold_hh", hh, 1);
    chk("hold_ss", ss, 1);

    // Out of range replaces 01:01:01 with pass-through values
    req0 = 1'b1; t0 = 28'd189388800; ts = cyc;
    push(0, 0, 0, 0, 0, 0, 0, 1, 0);
    wait_done(0, 20, c0);
    req0 = 1'b0;
    chk("oor_latency", c0 - ts, 3);

    // Reset pulse restores the pointer and clears range_err
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset2");
    rst = 1'b0;

    // Simultaneous requests: port 0 first, loser waits LAT+1
    @(negedge clk);
    req0 = 1'b1; t0 = 28'd0; req1 = 1'b1; t1 = 28'd5097600; ts = cyc;
    push(0, 0, 0, 0, 1, 1, 2020, 0, 1);
    push(1, 0, 0, 0, 29, 2, 2020, 0, 1);
    @(negedge clk);
    chk("sim_gnt_first", gnt, 2'b01);
    wait_done(0, 20, c0);
    req0 = 1'b0;
    chk("sim_latency0", c0 - ts, 3);
    chk("sim_gnt_done0", gnt, 0);
    @(negedge clk);
    chk("sim_gnt_second", gnt, 2'b10);
    wait_done(1, 20, c1);
    req1 = 1'b0;
    chk("sim_gap", c1 - c0, 3);
    chk("sim_gnt_end", gnt, 0);

    // Fairness: req0 held, req1 joins mid-conversion
    @(negedge clk);
    req0 = 1'b1; t0 = 28'd100;
    push(0, 0, 1, 40, 1, 1, 2020, 0, 1);
    @(negedge clk);
    req1 = 1'b1; t1 = 28'd126230400;
    push(1, 0, 0, 0, 1, 1, 2024, 0, 1);
    push(0, 0, 1, 40, 1, 1, 2020, 0, 1);
    wait_done(0, 20, c0);
    wait_done(1, 20, c1);
    req1 = 1'b0;
    chk("fair_gap01", c1 - c0, 3);
    wait_done(0, 20, c2);
    req0 = 1'b0;
    chk("fair_gap10", c2 - c1, 3);

    // Reset on the cycle after the grant
    @(negedge clk);
    req0 = 1'b1; t0 = 28'd3661;
    @(negedge clk);
    chk("rst_mid_gnt", gnt, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst_mid");
    rst = 1'b0; req0 = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0 || done1) ndone++;
    end
    chk("rst_mid_no_done", ndone, 0);
    req0 = 1'b1; t0 = 28'd3661; req1 = 1'b1; t1 = 28'd31622399; ts = cyc;
    push(0, 1, 1, 1, 1, 1, 2020, 0, 1);
    push(1, 23, 59, 59, 31, 12, 2020, 0, 1);
    @(negedge clk);
    chk("post_rst_gnt", gnt, 2'b01);
    wait_done(0, 20, c0);
    req0 = 1'b0;
    chk("post_rst_latency", c0 - ts, 3);
    wait_done(1, 20, c1);
    req1 = 1'b0;

    // LAT=1 and LAT=15 latency extremes
    @(negedge clk);
    r_req = 1'b1; r_t = 28'd31622399; ts = cyc;
    ca = -1; cb = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_done1 && ca < 0) begin
        ca = cyc;
        ares = '{32'(a_hh), 32'(a_mm), 32'(a_ss), 32'(a_dd), 32'(a_mo), 32'(a_yy)};
      end
      if (b_done1 && cb < 0) begin
        cb = cyc;
        bres = '{32'(b_hh), 32'(b_mm), 32'(b_ss), 32'(b_dd), 32'(b_mo), 32'(b_yy)};
      end
    end
    r_req = 1'b0;
    chk("lat1_latency", ca - ts, 2);
    chk("lat15_latency", cb - ts, 16);
    chk("lat1_result", {ares[0][7:0], ares[1][7:0], ares[2][7:0], ares[3][7:0],
                        ares[4][7:0], ares[5][15:0]} == {8'd23, 8'd59, 8'd59, 8'd31,
                        8'd12, 16'd2020} ? 1 : 0, 1);
    chk("lat15_result", {bres[0][7:0], bres[1][7:0], bres[2][7:0], bres[3][7:0],
                         bres[4][7:0], bres[5][15:0]} == {8'd23, 8'd59, 8'd59, 8'd31,
                         8'd12, 16'd2020} ? 1 : 0, 1);
    $display("lat1 done at %0d, lat15 done at %0d", ca - ts, cb - ts);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/time_conv_arbiter.md
# time_conv_arbiter

Shares one `binary_time_converter` instance between two requesters: the live-clock display path (port 0) and the event-timestamp path (port 1). The block arbitrates round-robin and latches the winner's 28-bit seconds count. It holds that count on the converter for a fixed number of multicycle settle cycles, then registers the calendar result and pulses a per-port done. It sits between the seconds counter / event logger and the display and log formatters.

## Interface
- `LAT`, default 2: settle cycles the operand is held on the converter before capture; legal range 1..15.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `req0` input 1: port-0 conversion request, level.
- `t0` input 28: port-0 seconds since 2020-01-01 00:00:00.
- `req1` input 1: port-1 conversion request, level.
- `t1` input 28: port-1 seconds since 2020-01-01 00:00:00.
- `gnt` output 2: one-hot, current owner of the converter; 0 when idle.
- `busy` output 1: conversion in progress.
- `done0`, `done1` output 1 each: one-cycle result-valid pulse for the respective port.
- `hh` output 5, `mm` output 6, `ss` output 6: registered time of day.
- `DD` output 5, `MM` output 4, `YYYY` output 11: registered date.
- `range_err` output 1: registered; set when captured t ≥ 189388800 (2026-01-01).

## Operation
- States: IDLE, HOLD.
- IDLE:
  - Eligible requesters are those with req high, excluding the port whose done is high this cycle.
  - One eligible requester: grant it.
  - Two eligible requesters: grant the port not served last. The last-served pointer resets to 1, so port 0 wins first.
  - On grant: latch `t_reg` from the winner's t, set `gnt`, set `busy`=1, cnt=LAT-1, go to HOLD.
- HOLD:
  - `t_reg` drives the converter and is frozen.
  - cnt≠0: decrement.
  - cnt=0: register all six converter outputs and `range_err`, pulse the owner's done, update the last-served pointer, clear `gnt` and `busy`, go to IDLE.
- Requesters hold req until their done; a t change after the grant edge is ignored.
- A req dropped before grant is withdrawn with no side effects. A req dropped during HOLD does not abort; done still pulses.
- A req still high in the cycle after done is a new request.
- Result outputs hold their last captured value between conversions and change only at capture.
- Out-of-range t: converter outputs are passed through unmodified (YYYY=0) with `range_err`=1. Consumers discard the result.

## Timing
- Reset, applied at any time including mid-HOLD:
  - State IDLE, `gnt`=0, `busy`=0, `done0`/`done1`=0, pointer=1.
  - `hh`, `mm`, `ss`, `DD`, `MM`, `YYYY`, `range_err` all 0.
  - An in-flight conversion is dropped with no done pulse.
- Latency: req sampled high in IDLE at edge E; done is high during the cycle after edge E+LAT. That is LAT+1 cycles req→done. Results are valid in the same cycle as done.
- Throughput: a back-to-back grant to the other port is possible in the done cycle, giving one conversion per LAT+1 cycles.
- `gnt` and `busy` rise in the cycle after the grant edge and fall in the done cycle.
- Exactly one of `done0`/`done1` is high at a time; never both.
- Simultaneous req0/req1 rising edge: the pointer decides, and the loser waits exactly LAT+1 cycles.

## Test plan
- Basic latency and decode, LAT=2, after reset: req0, t0=3661.
  - done0 3 cycles after the request is sampled.
  - Result 01:01:01 2020-01-01, `range_err`=0.
- Simultaneous requests: req0 (t0=0) and req1 (t1=5097600) raised together.
  - First done0 with 2020-01-01 00:00:00.
  - Then done1 3 cycles later with 2020-02-29 00:00:00.
  - `gnt` sequence 01, 10, 00.
- Fairness: req0 held continuously, re-requesting after each done; req1 raised with t1=126230400.
  - After the current port-0 conversion, port 1 is served next with 2024-01-01 00:00:00.
  - Grants then alternate 0, 1, 0.
- Out of range: t0=189388800.
  - `range_err`=1, YYYY=0.
  - Previous hh/mm/ss outputs are replaced by the converter's pass-through values.
- Reset mid-HOLD: assert `rst` on the cycle after the grant.
  - No done pulse.
  - All outputs 0.
  - Next request is served normally with the pointer favoring port 0.
- LAT=1 and LAT=15 builds, t1=31622399: done at 2 and 16 cycles respectively, result 23:59:59 2020-12-31.
